// File: rtl/call_dispatcher_if.sv
// Ticket/call bundle between the dispatcher, the ticket kiosk and the counter service block.
// The slave side belongs to the dispatcher; the master side drives requests and busy flags.
interface call_dispatcher_if;
    logic       take_ticket;
    logic [4:0] counter_busy;
    logic       ticket_valid;
    logic [5:0] ticket_no;
    logic       ticket_reject;
    logic [2:0] counter_call;
    logic [5:0] number_call;
    logic [5:0] waiting_cnt;

    modport master (
        output take_ticket, counter_busy,
        input  ticket_valid, ticket_no, ticket_reject, counter_call, number_call, waiting_cnt
    );

    modport slave (
        input  take_ticket, counter_busy,
        output ticket_valid, ticket_no, ticket_reject, counter_call, number_call, waiting_cnt
    );
endinterface

// File: rtl/call_dispatcher.sv
// Ticket issue and counter-call scheduler for counters A..E; CALL_FIXED_PRIO_EN selects fixed A>E priority.
// Latency: ticket 1 cycle; call 2 cycles from eligibility (decide, then call), then CALL_GAP idle cycles.
// Backpressure: full queue (MAX_WAIT) rejects requests; no counter eligible keeps the FSM idle.
module call_dispatcher #(
    parameter int MAX_WAIT     = 63,
    parameter int CALL_HOLDOFF = 2,
    parameter int CALL_GAP     = 1
) (
    input  logic               clk,
    input  logic               rst,
    call_dispatcher_if.slave   bus
);
    localparam int HW = $clog2(CALL_HOLDOFF + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALL, S_GAP} state_t;

    state_t     state_q;
    logic [5:0] next_ticket_q;
    logic [5:0] next_call_q;
    logic [5:0] wait_q, wait_d;
    logic [2:0] pick_q;
    logic [3:0] gap_q;
    logic [HW-1:0] hold_q [5];
`ifndef CALL_FIXED_PRIO_EN
    logic [2:0] rr_ptr_q;
`endif

    logic       ticket_valid_q, ticket_reject_q;
    logic [5:0] ticket_no_q, number_call_q;
    logic [2:0] counter_call_q;

    logic       accept, call_fire, pick_found;
    logic [2:0] pick_idx;
    logic [4:0] eligible;

    function automatic logic [5:0] inc_wrap(input logic [5:0] v);
        return (v == 6'd63) ? 6'd1 : v + 6'd1;
    endfunction

    assign accept    = bus.take_ticket && (wait_q < 6'(MAX_WAIT));
    assign call_fire = (state_q == S_CALL);

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            eligible[k] = !bus.counter_busy[k] && (hold_q[k] == '0);
        end
    end

    // First eligible counter scanning from the round-robin pointer (or from A in fixed priority).
    always_comb begin
        int c;
        c          = 0;
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        for (int i = 0; i < 5; i++) begin
`ifdef CALL_FIXED_PRIO_EN
            c = i;
`else
            c = int'(rr_ptr_q) + i;
            if (c >= 5) c = c - 5;
`endif
            if (!pick_found && eligible[3'(c)]) begin
                pick_found = 1'b1;
                pick_idx   = 3'(c);
            end
        end
    end

    // Accept and call in the same cycle cancel out.
    always_comb begin
        wait_d = wait_q;
        if (accept && !call_fire)      wait_d = wait_q + 6'd1;
        else if (!accept && call_fire) wait_d = wait_q - 6'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            next_ticket_q   <= 6'd1;
            next_call_q     <= 6'd1;
            wait_q          <= 6'd0;
            pick_q          <= 3'd0;
            gap_q           <= 4'd0;
            for (int k = 0; k < 5; k++) hold_q[k] <= '0;
`ifndef CALL_FIXED_PRIO_EN
            rr_ptr_q        <= 3'd0;
`endif
            ticket_valid_q  <= 1'b0;
            ticket_reject_q <= 1'b0;
            ticket_no_q     <= 6'd0;
            counter_call_q  <= 3'd0;
            number_call_q   <= 6'd0;
        end else begin
            ticket_valid_q  <= accept;
            ticket_reject_q <= bus.take_ticket && !accept;
            if (accept) begin
                ticket_no_q   <= next_ticket_q;
                next_ticket_q <= inc_wrap(next_ticket_q);
            end
            wait_q <= wait_d;

            for (int k = 0; k < 5; k++) begin
                if (call_fire && (pick_q == 3'(k))) hold_q[k] <= HW'(CALL_HOLDOFF);
                else if (hold_q[k] != '0)           hold_q[k] <= hold_q[k] - 1'b1;
            end

            counter_call_q <= 3'd0;
            number_call_q  <= 6'd0;
            case (state_q)
                S_IDLE: begin
                    // The pick is frozen here; a counter going busy afterwards is still called.
                    if (wait_q != 6'd0 && pick_found) begin
                        pick_q  <= pick_idx;
                        state_q <= S_CALL;
                    end
                end
                S_CALL: begin
                    counter_call_q <= pick_q + 3'd1;
                    number_call_q  <= next_call_q;
                    next_call_q    <= inc_wrap(next_call_q);
`ifndef CALL_FIXED_PRIO_EN
                    rr_ptr_q       <= (pick_q == 3'd4) ? 3'd0 : pick_q + 3'd1;
`endif
                    if (CALL_GAP > 0) begin
                        gap_q   <= 4'(CALL_GAP - 1);
                        state_q <= S_GAP;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_q == 4'd0) state_q <= S_IDLE;
                    else               gap_q   <= gap_q - 4'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ticket_valid  = ticket_valid_q;
    assign bus.ticket_no     = ticket_no_q;
    assign bus.ticket_reject = ticket_reject_q;
    assign bus.counter_call  = counter_call_q;
    assign bus.number_call   = number_call_q;
    assign bus.waiting_cnt   = wait_q;
endmodule

// File: tb/tb_call_dispatcher.sv
// Directed and randomized bench for call_dispatcher against an edge-indexed reference model.
module tb_call_dispatcher;
    localparam int MAX_WAIT = 63;
    localparam int HOLD     = 2;
    localparam int GAP      = 1;

    logic clk = 1'b0;
    logic rst;
    call_dispatcher_if bus();

    call_dispatcher #(.MAX_WAIT(MAX_WAIT), .CALL_HOLDOFF(HOLD), .CALL_GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: edge counter plus "eligible again at edge N" timestamps.
    int m_e = 0;
    int m_next_ticket, m_next_call, m_wait, m_rr, m_pick, m_idle_from;
    int m_hold_until [5];
    bit m_pend;
    int exp_valid, exp_no, exp_rej, exp_call, exp_num;

    logic [4:0] svc_busy;
    logic [4:0] svc_pipe [3];
    int obs_ctr [8];
    int obs_num [8];
    int n_calls;
    int pct [5] = '{30, 70, 95, 10, 50};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_next_ticket = 1; m_next_call = 1; m_wait = 0; m_rr = 0; m_pick = 0;
        m_idle_from = 0; m_pend = 0;
        for (int k = 0; k < 5; k++) m_hold_until[k] = 0;
        exp_valid = 0; exp_no = 0; exp_rej = 0; exp_call = 0; exp_num = 0;
    endtask

    task automatic m_edge(input bit tk, input logic [4:0] busy);
        int  pre_wait;
        int  k;
        bit  call_now;
        bit  acc;
        pre_wait = m_wait;
        m_e++;
        exp_call = 0;
        exp_num  = 0;
        call_now = m_pend;
        if (call_now) begin
            exp_call    = m_pick + 1;
            exp_num     = m_next_call;
            m_next_call = (m_next_call == 63) ? 1 : m_next_call + 1;
            m_rr        = (m_pick + 1) % 5;
            m_hold_until[m_pick] = m_e + 1 + HOLD;
            m_idle_from = m_e + 1 + GAP;
            m_pend      = 0;
        end else if (m_e >= m_idle_from && pre_wait > 0) begin
            for (int i = 0; i < 5; i++) begin
`ifdef CALL_FIXED_PRIO_EN
                k = i;
`else
                k = (m_rr + i) % 5;
`endif
                if (!m_pend && !busy[k] && m_e >= m_hold_until[k]) begin
                    m_pend = 1;
                    m_pick = k;
                end
            end
        end
        acc       = tk && (pre_wait < MAX_WAIT);
        exp_valid = acc;
        exp_rej   = tk && !acc;
        if (acc) begin
            exp_no        = m_next_ticket;
            m_next_ticket = (m_next_ticket == 63) ? 1 : m_next_ticket + 1;
        end
        m_wait = pre_wait + int'(acc) - int'(call_now);
    endtask

    task automatic step(input bit tk, input logic [4:0] busy);
        bus.take_ticket  = tk;
        bus.counter_busy = busy;
        @(posedge clk);
        m_edge(tk, busy);
        #1;
        chk("ticket_valid",  bus.ticket_valid,  exp_valid);
        chk("ticket_no",     bus.ticket_no,     exp_no);
        chk("ticket_reject", bus.ticket_reject, exp_rej);
        chk("counter_call",  bus.counter_call,  exp_call);
        chk("number_call",   bus.number_call,   exp_num);
        chk("waiting_cnt",   bus.waiting_cnt,   m_wait);
    endtask

    // Service block: a called counter's busy flag reaches the dispatcher three edges later.
    task automatic svc_step(input bit tk);
        svc_busy    = svc_busy | svc_pipe[2];
        svc_pipe[2] = svc_pipe[1];
        svc_pipe[1] = svc_pipe[0];
        svc_pipe[0] = 5'b0;
        step(tk, svc_busy);
        if (exp_call != 0) svc_pipe[0][exp_call-1] = 1'b1;
        if (bus.counter_call != 3'd0 && n_calls < 8) begin
            obs_ctr[n_calls] = int'(bus.counter_call);
            obs_num[n_calls] = int'(bus.number_call);
            n_calls++;
        end
    endtask

    task automatic svc_clear();
        for (int i = 0; i < 3; i++) svc_pipe[i] = 5'b0;
        svc_busy = 5'b11111;
        n_calls  = 0;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        bus.take_ticket = 1'b0;
        #2 rst = 1'b0;
        m_reset();
        svc_clear();
    endtask

    task automatic wait_pend(input int budget);
        for (int n = 0; n < budget && !m_pend; n++) svc_step(1'b0);
        chk("call_decision_timeout", m_pend, 1);
    endtask

    initial begin
        rst = 1'b1;
        bus.take_ticket  = 1'b0;
        bus.counter_busy = 5'b11111;
        m_reset();
        svc_clear();
        #12;
        chk("rst_ticket_valid",  bus.ticket_valid,  0);
        chk("rst_ticket_no",     bus.ticket_no,     0);
        chk("rst_ticket_reject", bus.ticket_reject, 0);
        chk("rst_counter_call",  bus.counter_call,  0);
        chk("rst_number_call",   bus.number_call,   0);
        chk("rst_waiting_cnt",   bus.waiting_cnt,   0);
        rst = 1'b0;

        // Three tickets, every counter busy.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'b11111);
            chk("t1_ticket_no", bus.ticket_no, i + 1);
        end
        chk("t1_waiting", bus.waiting_cnt, 3);

        // All counters freed: A,B,C called in order, each once.
        svc_busy = 5'b00000;
        for (int n = 0; n < 40 && (m_wait > 0 || m_pend); n++) svc_step(1'b0);
        chk("t2_n_calls", n_calls, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_call_ctr", obs_ctr[i], i + 1);
            chk("t2_call_num", obs_num[i], i + 1);
        end
        chk("t2_drained", bus.waiting_cnt, 0);

        // Only A idle, slow busy feedback: A must not be re-called inside its holdoff.
        do_reset();
        for (int i = 0; i < 2; i++) step(1'b1, 5'b11111);
        svc_busy = 5'b11110;
        for (int n = 0; n < 14; n++) begin
            if (n == 6) svc_busy[1] = 1'b0;
            svc_step(1'b0);
        end
        chk("t3_n_calls", n_calls, 2);
        chk("t3_first_ctr", obs_ctr[0], 1);
        chk("t3_first_num", obs_num[0], 1);
        chk("t3_second_ctr", obs_ctr[1], 2);
        chk("t3_second_num", obs_num[1], 2);

        // Fill to MAX_WAIT, reject, then wrap the ticket number.
        do_reset();
        for (int i = 0; i < 63; i++) step(1'b1, 5'b11111);
        chk("t4_full", bus.waiting_cnt, 63);
        step(1'b1, 5'b11111);
        chk("t4_reject", bus.ticket_reject, 1);
        chk("t4_no_hold", bus.ticket_no, 63);
        svc_busy = 5'b11110;
        for (int n = 0; n < 10 && n_calls == 0; n++) svc_step(1'b0);
        chk("t4_call_ctr", obs_ctr[0], 1);
        chk("t4_call_num", obs_num[0], 1);
        svc_step(1'b1);
        chk("t4_wrap_valid", bus.ticket_valid, 1);
        chk("t4_wrap_no", bus.ticket_no, 1);

        // Ticket and call on the same edge.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 5'b11111);
        svc_busy = 5'b11110;
        wait_pend(10);
        svc_step(1'b1);
        chk("t5_valid", bus.ticket_valid, 1);
        chk("t5_call", bus.counter_call, 1);
        chk("t5_waiting", bus.waiting_cnt, 5);

        // Reset asserted while a call is on the outputs.
        svc_busy[1] = 1'b0;
        wait_pend(20);
        svc_step(1'b0);
        chk("t6_call_seen", bus.counter_call, 2);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_call", bus.counter_call, 0);
        chk("t6_rst_num", bus.number_call, 0);
        chk("t6_rst_wait", bus.waiting_cnt, 0);
        #1 rst = 1'b0;
        m_reset();
        svc_clear();
        step(1'b1, 5'b11111);
        chk("t6_restart_no", bus.ticket_no, 1);

        // Randomized traffic with random counter release.
        do_reset();
        for (int s = 0; s < 5; s++) begin
            for (int n = 0; n < 500; n++) begin
                svc_step($urandom_range(0, 99) < pct[s]);
                for (int k = 0; k < 5; k++) begin
                    if ($urandom_range(0, 7) == 0) svc_busy[k] = 1'b0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
